// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART character type and receive FIFO defaults
package uart_pkg;

  typedef logic [7:0] uart_char_t;

  localparam int UART_RX_FIFO_DEPTH_DFLT = 8;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver push side and show-ahead consumer side of uart_rx_fifo
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH_DFLT
) ();

  localparam int AW = $clog2(DEPTH);

  logic       ch_vld;
  uart_char_t ch;
  logic       pop_vld;
  logic       pop_rdy;
  uart_char_t pop_data;
  logic [AW:0] cnt;
  logic       full;
  logic       empty;
  logic       ovf;
  logic       ovf_clr;
  logic [AW:0] thr;
  logic       irq;

  modport master (
    output ch_vld, ch, pop_rdy, ovf_clr, thr,
    input  pop_vld, pop_data, cnt, full, empty, ovf, irq
  );

  modport slave (
    input  ch_vld, ch, pop_rdy, ovf_clr, thr,
    output pop_vld, pop_data, cnt, full, empty, ovf, irq
  );

endinterface

// File: rtl/uart_fifo_ram.sv
// rtl/uart_fifo_ram.sv - DEPTH x 8 character storage, one write port, one asynchronous read port
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter  int DEPTH = UART_RX_FIFO_DEPTH_DFLT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  uart_char_t    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output uart_char_t    rd_data_o
);

  // No reset: occupancy is tracked by the pointers, so stale entries are never consumed.
  uart_char_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead receive character FIFO with sticky overflow flag
// Optional threshold interrupt enabled by defining UART_RX_FIFO_IRQ_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH_DFLT
) (
  input logic           clk,
  input logic           rst_n,
  uart_rx_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        ovf_q, ovf_d;
  logic        full_w, empty_w;
  logic        push, pop, drop;
  uart_char_t  rd_data;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pop  = ~empty_w & bus.pop_rdy;
  assign push = bus.ch_vld & (~full_w | pop);
  assign drop = bus.ch_vld & full_w & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  uart_fifo_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (bus.ch),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (rd_data)
  );

  assign bus.pop_vld  = ~empty_w;
  assign bus.pop_data = rd_data;
  assign bus.cnt      = wr_ptr_q - rd_ptr_q;
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.ovf      = ovf_q;

`ifdef UART_RX_FIFO_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = (bus.cnt >= bus.thr) | ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.irq = irq_q;
`else
  logic unused_thr;

  assign unused_thr = ^bus.thr;
  assign bus.irq    = 1'b0;
`endif

  a_full_empty_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(full_w && empty_w));
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    bus.cnt <= (AW+1)'(DEPTH));

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo with DEPTH 8 and DEPTH 4 instances
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int D0 = 8;
  localparam int D1 = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       in_vld [2];
  logic       in_rdy [2];
  logic       in_clr [2];
  logic [7:0] in_ch  [2];
  int         in_thr [2];

  uart_rx_fifo_if #(.DEPTH(D0)) bus0 ();
  uart_rx_fifo_if #(.DEPTH(D1)) bus1 ();

  assign bus0.ch_vld  = in_vld[0];
  assign bus0.ch      = in_ch[0];
  assign bus0.pop_rdy = in_rdy[0];
  assign bus0.ovf_clr = in_clr[0];
  assign bus0.thr     = 4'(in_thr[0]);
  assign bus1.ch_vld  = in_vld[1];
  assign bus1.ch      = in_ch[1];
  assign bus1.pop_rdy = in_rdy[1];
  assign bus1.ovf_clr = in_clr[1];
  assign bus1.thr     = 3'(in_thr[1]);

  uart_rx_fifo #(.DEPTH(D0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  uart_rx_fifo #(.DEPTH(D1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int o_cnt [2], o_vld [2], o_data [2], o_full [2], o_empty [2], o_ovf [2], o_irq [2];
  assign o_cnt[0]   = int'(bus0.cnt);
  assign o_vld[0]   = int'(bus0.pop_vld);
  assign o_data[0]  = int'(bus0.pop_data);
  assign o_full[0]  = int'(bus0.full);
  assign o_empty[0] = int'(bus0.empty);
  assign o_ovf[0]   = int'(bus0.ovf);
  assign o_irq[0]   = int'(bus0.irq);
  assign o_cnt[1]   = int'(bus1.cnt);
  assign o_vld[1]   = int'(bus1.pop_vld);
  assign o_data[1]  = int'(bus1.pop_data);
  assign o_full[1]  = int'(bus1.full);
  assign o_empty[1] = int'(bus1.empty);
  assign o_ovf[1]   = int'(bus1.ovf);
  assign o_irq[1]   = int'(bus1.irq);

  // Reference model: a plain queue of characters plus sticky overflow and interrupt bits.
  logic [7:0] mq [2][$];
  logic       movf [2];
  logic       mirq [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int vld; int ch; int rdy; int clr;
    int cnt; int pv; int data; int full; int ovf;
  } vec_t;
  vec_t tbl [$];

  function automatic int depth_of(input int id);
    return (id == 0) ? D0 : D1;
  endfunction

  task automatic chk(input string name, input int id, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[dut%0d]: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, id, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    for (int id = 0; id < 2; id++) begin
      int n;
      n = mq[id].size();
      chk({tag, ".cnt"},     id, o_cnt[id],   n);
      chk({tag, ".empty"},   id, o_empty[id], int'(n == 0));
      chk({tag, ".full"},    id, o_full[id],  int'(n == depth_of(id)));
      chk({tag, ".pop_vld"}, id, o_vld[id],   int'(n != 0));
      chk({tag, ".ovf"},     id, o_ovf[id],   int'(movf[id]));
      chk({tag, ".irq"},     id, o_irq[id],   int'(mirq[id]));
      if (n != 0) chk({tag, ".pop_data"}, id, o_data[id], int'(mq[id][0]));
    end
  endtask

  task automatic set_in(input int id, input int vld, input int ch, input int rdy, input int clr);
    in_vld[id] = 1'(vld);
    in_ch[id]  = 8'(ch);
    in_rdy[id] = 1'(rdy);
    in_clr[id] = 1'(clr);
  endtask

  task automatic step(input string tag);
    logic pop_m [2];
    logic push_m [2];
    logic drop_m [2];
    logic irq_m [2];
    for (int id = 0; id < 2; id++) begin
      int n;
      n = mq[id].size();
      pop_m[id]  = (n > 0) && in_rdy[id];
      push_m[id] = in_vld[id] && ((n < depth_of(id)) || pop_m[id]);
      drop_m[id] = in_vld[id] && !push_m[id];
`ifdef UART_RX_FIFO_IRQ_EN
      irq_m[id]  = (n >= in_thr[id]) || movf[id];
`else
      irq_m[id]  = 1'b0;
`endif
    end
    @(posedge clk);
    #1;
    if (rst_n) begin
      for (int id = 0; id < 2; id++) begin
        if (pop_m[id]) void'(mq[id].pop_front());
        if (push_m[id]) mq[id].push_back(in_ch[id]);
        if (drop_m[id]) movf[id] = 1'b1;
        else if (in_clr[id]) movf[id] = 1'b0;
        mirq[id] = irq_m[id];
      end
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int id = 0; id < 2; id++) begin
      mq[id].delete();
      movf[id] = 1'b0;
      mirq[id] = 1'b0;
      set_in(id, 1, 8'hAA, 1, 0);
    end
    #1;
    check_all("rst_async");
    step("rst_hold");
    step("rst_hold");
    for (int id = 0; id < 2; id++) set_in(id, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  function automatic void add(input int vld, input int ch, input int rdy, input int clr,
                              input int cnt, input int pv, input int data, input int full,
                              input int ovf);
    vec_t v;
    v.vld = vld; v.ch = ch; v.rdy = rdy; v.clr = clr;
    v.cnt = cnt; v.pv = pv; v.data = data; v.full = full; v.ovf = ovf;
    tbl.push_back(v);
  endfunction

  initial begin
    for (int id = 0; id < 2; id++) begin
      set_in(id, 0, 0, 0, 0);
      movf[id] = 1'b0;
      mirq[id] = 1'b0;
    end
    in_thr[0] = 3;
    in_thr[1] = 2;

    // Expected values after each clock edge, for the DEPTH=8 instance.
    add(1, 8'h41, 1, 0, 1, 1, 8'h41, 0, 0);
    add(0, 0,     1, 0, 0, 0, 0,     0, 0);
    for (int k = 0; k < 8; k++) add(1, k, 0, 0, k + 1, 1, 8'h00, int'(k == 7), 0);
    add(1, 8'h08, 0, 0, 8, 1, 8'h00, 1, 1);
    add(1, 8'h09, 0, 1, 8, 1, 8'h00, 1, 1);
    add(0, 0,     0, 1, 8, 1, 8'h00, 1, 0);
    add(1, 8'h55, 1, 0, 8, 1, 8'h01, 1, 0);
    for (int k = 1; k <= 7; k++) add(0, 0, 1, 0, 8 - k, 1, (k < 7) ? k + 1 : 8'h55, 0, 0);
    add(0, 0,     1, 0, 0, 0, 0,     0, 0);

    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      set_in(0, tbl[i].vld, tbl[i].ch, tbl[i].rdy, tbl[i].clr);
      set_in(1, 0, 0, 0, 0);
      step($sformatf("vec%0d", i));
      chk("tbl.cnt",  0, o_cnt[0],  tbl[i].cnt);
      chk("tbl.vld",  0, o_vld[0],  tbl[i].pv);
      chk("tbl.full", 0, o_full[0], tbl[i].full);
      chk("tbl.ovf",  0, o_ovf[0],  tbl[i].ovf);
      if (tbl[i].pv != 0) chk("tbl.data", 0, o_data[0], tbl[i].data);
    end
    set_in(0, 0, 0, 0, 0);

    // Threshold interrupt: three pushes, then reset mid-stream with five entries.
    for (int k = 0; k < 3; k++) begin
      set_in(0, 1, 8'hC0 + k, 0, 0);
      step("irq_push");
    end
`ifdef UART_RX_FIFO_IRQ_EN
    chk("irq.at_3rd_push", 0, o_irq[0], 0);
`else
    chk("irq.tied_low", 0, o_irq[0], 0);
`endif
    set_in(0, 1, 8'hC3, 0, 0);
    step("irq_push");
`ifdef UART_RX_FIFO_IRQ_EN
    chk("irq.after_3rd_push", 0, o_irq[0], 1);
`else
    chk("irq.tied_low", 0, o_irq[0], 0);
`endif
    set_in(0, 1, 8'hC4, 0, 0);
    step("irq_push");
    chk("five_entries.cnt", 0, o_cnt[0], 5);
    do_reset();
    chk("rst5.cnt", 0, o_cnt[0], 0);
    chk("rst5.irq", 0, o_irq[0], 0);
    chk("rst5.pop_vld", 0, o_vld[0], 0);

    // Pointer wrap through DEPTH=4: two entries resident, 20 same-cycle push/pop pairs.
    set_in(1, 1, 8'hE0, 0, 0);
    step("wrap_fill");
    set_in(1, 1, 8'hE1, 0, 0);
    step("wrap_fill");
    for (int i = 0; i < 20; i++) begin
      set_in(1, 1, 8'($urandom), 1, 0);
      step("wrap_pair");
    end
    chk("wrap.cnt", 1, o_cnt[1], 2);
    set_in(1, 0, 0, 1, 0);
    step("wrap_drain");
    step("wrap_drain");
    chk("wrap.empty", 1, o_empty[1], 1);

    // Randomised traffic on both instances, biased first toward filling then toward draining.
    for (int c = 0; c < 400; c++) begin
      for (int id = 0; id < 2; id++) begin
        int rdy_pct;
        rdy_pct = (c < 200) ? 25 : 75;
        set_in(id, int'($urandom_range(0, 99) < 60), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 99) < rdy_pct), int'($urandom_range(0, 99) < 5));
        if ($urandom_range(0, 15) == 0) in_thr[id] = int'($urandom_range(0, depth_of(id)));
      end
      step("rand");
      if (c == 300) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of character entries (power of two, 2..256).
REQ-002 SHALL derive localparam AW = log2(DEPTH); the count width is AW+1.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ch_vld  input  1  single-cycle strobe from the UART receiver: character complete.
REQ-006 SHALL have port ch  input  8  received character, qualified by ch_vld.
REQ-007 SHALL have port pop_vld  output  1  head entry available.
REQ-008 SHALL have port pop_rdy  input  1  consumer takes the head entry when pop_vld is high.
REQ-009 SHALL have port pop_data  output  8  head character, valid while pop_vld is high.
REQ-010 SHALL have port cnt  output  AW+1  current occupancy, 0..DEPTH.
REQ-011 SHALL have ports full and empty, output, 1 bit each: cnt==DEPTH and cnt==0.
REQ-012 SHALL have port ovf  output  1  sticky flag: a character was dropped.
REQ-013 SHALL have port ovf_clr  input  1  clears ovf.
REQ-014 SHALL have port thr  input  AW+1  interrupt threshold (used only with the macro in REQ-031).
REQ-015 SHALL have port irq  output  1  level interrupt (see REQ-031 and REQ-032).

Function
REQ-016 SHALL push ch on ch_vld when not full, or when full and a pop occurs in the same cycle.
REQ-017 SHALL drop ch on ch_vld when full with no same-cycle pop, leave contents unchanged, and set ovf the next cycle.
REQ-018 SHALL define pop as pop_vld & pop_rdy; pop_rdy while empty has no effect.
REQ-019 SHALL present pop_data show-ahead: a combinational read of the head entry, with no extra pop latency.
REQ-020 SHALL give write-to-read latency of 1 cycle: a push into an empty FIFO raises pop_vld in the following cycle.
REQ-021 SHALL NOT bypass the write into pop_data in the same cycle.
REQ-022 SHALL hold cnt unchanged on a simultaneous push and pop, and update it 1 cycle after the event.
REQ-023 SHALL use read/write pointers of AW+1 bits that wrap modulo 2*DEPTH.
REQ-024 SHALL define full as pointer MSBs differing with equal low bits, and empty as equal pointers.
REQ-025 SHALL resolve ovf_clr asserted in the same cycle as a drop to ovf=1 (set wins).
REQ-026 SHALL make pop_data X-safe when empty: it outputs the stale entry and consumers ignore it.

Reset
REQ-027 SHALL on rst_n low, at any time including mid-stream, clear both pointers and ovf, and discard all contents.
REQ-028 SHALL drive reset values pop_vld=0, cnt=0, empty=1, full=0, ovf=0, irq=0.
REQ-029 SHALL leave the storage array unreset, with no functional dependence on its contents.
REQ-030 SHALL ignore ch_vld while rst_n is low.

Configuration
REQ-031 SHALL, with macro UART_RX_FIFO_IRQ_EN defined, register irq = (cnt >= thr) | ovf, updating 1 cycle after cnt or ovf changes; thr=0 forces irq=1.
REQ-032 SHALL, without UART_RX_FIFO_IRQ_EN, tie irq to 0, leave thr unused, and remove the threshold logic.

Structure
REQ-033 SHALL place the uart_char_t (8-bit) typedef and the UART_RX_FIFO_DEPTH_DFLT constant in shared package uart_pkg.
REQ-034 SHALL instantiate exactly one sub-module, uart_fifo_ram: DEPTH x 8 storage, 1 write port, 1 async read port, no reset.
REQ-035 SHALL keep the pointer, count, flag and irq logic in uart_rx_fifo.

Verification
REQ-036 SHALL cover: push 0x41 into empty FIFO, pop_rdy=1 -> pop_vld rises next cycle with pop_data=0x41, then empty=1 one cycle after the pop.
REQ-037 SHALL cover: DEPTH=8, push 0x00..0x08 with no pops -> full=1 after the 8th push, 9th char dropped, ovf=1, pops return 0x00..0x07 in order.
REQ-038 SHALL cover: full FIFO, ch_vld and pop in the same cycle with ch=0x55 -> cnt stays 8, ovf stays 0, 0x55 is popped last.
REQ-039 SHALL cover: 20 push/pop pairs through DEPTH=4 -> pointer wrap is correct and data matches the scoreboard.
REQ-040 SHALL cover: ovf=1, then ovf_clr with a same-cycle drop -> ovf stays 1; ovf_clr alone -> ovf=0 next cycle.
REQ-041 SHALL cover: UART_RX_FIFO_IRQ_EN defined with thr=3 -> irq rises the cycle after the 3rd push; rst_n pulsed with 5 entries -> cnt=0, irq=0, pop_vld=0.
